// File: rtl/if_id_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg_pkg
//  Description : Shared pipeline definitions. Holds the reset fetch address,
//                the bubble instruction and the IF/ID state encoding. The PC
//                block uses the same package.
//  Revision    : 1.0  initial release
// ============================================================================
package if_id_reg_pkg;

    // First fetch address after reset
    localparam logic [31:0] C_RESET_PC  = 32'h0040_0000;

    // Bubble instruction: sll $0,$0,0
    localparam logic [31:0] C_NOP_INSTR = 32'h0000_0000;

    // IF/ID control states
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } state_e;

endpackage : if_id_reg_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register for a synchronous-read instruction
//                memory. A fetch tag pairs each returned word with the address
//                issued one cycle earlier. Stall freezes ID, flush kills both
//                the in-flight fetch and the ID contents.
//  Revision    : 1.0  initial release
// ============================================================================
module if_id_reg
    import if_id_reg_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = C_RESET_PC,
    parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,        // asynchronous, active-low
    input  logic [31:0] if_pc,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_instr,
    output logic        id_valid
);

    state_e      r_state;
    logic [31:0] r_fetch_pc;
    logic        r_fetch_live;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_instr;
    logic        r_id_valid;

    state_e      w_state_next;
    logic [31:0] w_fetch_pc_next;
    logic        w_fetch_live_next;
    logic [31:0] w_id_pc_next;
    logic [31:0] w_id_instr_next;
    logic        w_id_valid_next;

    // Memory is addressed straight from the PC; a stall keeps the last word
    assign imem_addr = if_pc;
    assign imem_en   = ~stall;

    // Next-state and next-register logic; everything holds by default
    always_comb begin
        w_state_next      = r_state;
        w_fetch_pc_next   = r_fetch_pc;
        w_fetch_live_next = r_fetch_live;
        w_id_pc_next      = r_id_pc;
        w_id_instr_next   = r_id_instr;
        w_id_valid_next   = r_id_valid;

        if (flush) begin
            // Flush beats stall: bubble ID and mark the word in flight dead
            w_id_instr_next   = NOP_INSTR;
            w_id_valid_next   = 1'b0;
            w_fetch_live_next = 1'b0;
            if (!stall) begin
                w_fetch_pc_next = if_pc;
            end
            w_state_next      = SQUASH;
        end else if (stall) begin
            // Freeze everything; a pending squash is remembered until release
            w_state_next = (r_state == SQUASH) ? SQUASH : HOLD;
        end else begin
            case (r_state)
                SQUASH: begin
                    // Word returning now belongs to the killed fetch
                    w_id_instr_next   = NOP_INSTR;
                    w_id_valid_next   = 1'b0;
                    w_fetch_pc_next   = if_pc;
                    w_fetch_live_next = 1'b1;
                    w_state_next      = RUN;
                end
                default: begin
                    // RUN, or HOLD released on this edge: advance one slot
                    w_id_pc_next      = r_fetch_pc;
                    w_id_instr_next   = r_fetch_live ? imem_rdata : NOP_INSTR;
                    w_id_valid_next   = r_fetch_live;
                    w_fetch_pc_next   = if_pc;
                    w_fetch_live_next = 1'b1;
                    w_state_next      = RUN;
                end
            endcase
        end
    end

    // State, fetch tag and ID registers; reset discards any in-flight fetch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= SQUASH;
            r_fetch_pc   <= RESET_PC;
            r_fetch_live <= 1'b0;
            r_id_pc      <= RESET_PC;
            r_id_instr   <= NOP_INSTR;
            r_id_valid   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_fetch_pc   <= w_fetch_pc_next;
            r_fetch_live <= w_fetch_live_next;
            r_id_pc      <= w_id_pc_next;
            r_id_instr   <= w_id_instr_next;
            r_id_valid   <= w_id_valid_next;
        end
    end

    assign id_pc       = r_id_pc;
    assign id_pc_plus4 = r_id_pc + 32'd4;
    assign id_instr    = r_id_instr;
    assign id_valid    = r_id_valid;

endmodule : if_id_reg
`default_nettype wire

// File: tb/tb_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_reg
//  Description : Self-checking bench for if_id_reg with a simple PC block,
//                a synchronous-read instruction memory and a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_id_reg;
    import if_id_reg_pkg::*;

    localparam logic [31:0] C_RST = 32'h0040_0000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] target = 32'h0;
    logic [31:0] pc_q  = C_RST;
    logic [31:0] imem_rdata = 32'h0;

    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic        id_valid;

    int n_chk = 0;
    int n_err = 0;

    if_id_reg dut (
        .clk         (clk),
        .reset       (rst_n),
        .if_pc       (pc_q),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .flush       (flush),
        .imem_addr   (imem_addr),
        .imem_en     (imem_en),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_instr    (id_instr),
        .id_valid    (id_valid)
    );

    always #5 clk = ~clk;

    // Memory contents: one fixed word at the reset address, a pattern elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == C_RST) ? 32'h2008_0005 : (a ^ 32'h8C00_0000);
    endfunction

    // Instruction memory with one-cycle read latency
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_word(imem_addr);
    end

    // PC block: redirect on flush, advance when not stalled
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pc_q <= C_RST;
        else if (flush)  pc_q <= target;
        else if (!stall) pc_q <= pc_q + 32'd4;
    end

    // Reference model: ID takes the word at the last accepted fetch address,
    // except that a flush bubbles ID and also kills the next accepted slot.
    logic [31:0] m_pc    = C_RST;
    logic [31:0] m_instr = 32'h0;
    logic        m_valid = 1'b0;
    logic [31:0] m_fetch = C_RST;
    logic        m_kill  = 1'b1;

    always @(negedge rst_n) begin
        m_pc = C_RST; m_instr = 32'h0; m_valid = 1'b0; m_fetch = C_RST; m_kill = 1'b1;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc = C_RST; m_instr = 32'h0; m_valid = 1'b0; m_fetch = C_RST; m_kill = 1'b1;
        end else if (flush) begin
            m_valid = 1'b0; m_instr = 32'h0; m_kill = 1'b1;
        end else if (!stall) begin
            if (m_kill) begin
                m_valid = 1'b0; m_instr = 32'h0; m_kill = 1'b0;
            end else begin
                m_pc = m_fetch; m_instr = mem_word(m_fetch); m_valid = 1'b1;
            end
            m_fetch = pc_q;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("m.id_pc",     id_pc,          m_pc);
        chk("m.id_instr",  id_instr,       m_instr);
        chk("m.id_valid",  {31'b0, id_valid},    {31'b0, m_valid});
        chk("m.plus4",     id_pc_plus4,    m_pc + 32'd4);
        chk("m.imem_en",   {31'b0, imem_en},     {31'b0, ~stall});
        chk("m.imem_addr", imem_addr,      pc_q);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst.valid", {31'b0, id_valid}, 32'd0);
        chk("rst.pc",    id_pc,    32'h0040_0000);
        chk("rst.instr", id_instr, 32'h0);
        chk("rst.plus4", id_pc_plus4, 32'h0040_0004);

        // Release: first edge is a bubble, second edge delivers the first word
        rst_n = 1'b1;
        step();
        chk("rel1.valid", {31'b0, id_valid}, 32'd0);
        step();
        chk("rel2.pc",    id_pc,       32'h0040_0000);
        chk("rel2.instr", id_instr,    32'h2008_0005);
        chk("rel2.valid", {31'b0, id_valid}, 32'd1);
        chk("rel2.plus4", id_pc_plus4, 32'h0040_0004);
        step();
        step();
        chk("run.pc", id_pc, 32'h0040_0008);

        // Flush while 0x00400008 sits in ID
        flush = 1'b1; target = 32'h0040_0100;
        step();
        flush = 1'b0;
        chk("fl1.valid", {31'b0, id_valid}, 32'd0);
        chk("fl1.instr", id_instr, 32'h0);
        step();
        chk("fl2.valid", {31'b0, id_valid}, 32'd0);
        step();
        chk("fl3.pc",    id_pc,    32'h0040_0100);
        chk("fl3.valid", {31'b0, id_valid}, 32'd1);
        chk("fl3.instr", id_instr, 32'h8C40_0100);
        step();

        // Three-cycle stall with 0x00400104 in ID
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stl.pc",    id_pc, 32'h0040_0104);
            chk("stl.valid", {31'b0, id_valid}, 32'd1);
            chk("stl.en",    {31'b0, imem_en},  32'd0);
        end
        stall = 1'b0;
        step();
        chk("stl.next", id_pc, 32'h0040_0108);
        step();
        chk("stl.after", id_pc, 32'h0040_010C);

        // Flush and stall together, then stall held in the squash slot
        flush = 1'b1; stall = 1'b1; target = 32'h0040_0200;
        step();
        flush = 1'b0;
        chk("fs.valid", {31'b0, id_valid}, 32'd0);
        chk("fs.state", {30'b0, dut.r_state}, 32'd2);
        repeat (2) step();
        chk("fs.hold", {30'b0, dut.r_state}, 32'd2);
        stall = 1'b0;
        step();
        chk("fs.bubble", {31'b0, id_valid}, 32'd0);
        step();
        chk("fs.pc",    id_pc, 32'h0040_0200);
        chk("fs.valid", {31'b0, id_valid}, 32'd1);
        step();

        // Back-to-back flush, the second one landing on the top address
        flush = 1'b1; target = 32'h0040_0300;
        step();
        target = 32'hFFFF_FFFC;
        step();
        flush = 1'b0;
        chk("ff.valid", {31'b0, id_valid}, 32'd0);
        step();
        chk("ff.bubble", {31'b0, id_valid}, 32'd0);
        step();
        chk("wrap.pc",    id_pc,       32'hFFFF_FFFC);
        chk("wrap.plus4", id_pc_plus4, 32'h0000_0000);
        chk("wrap.valid", {31'b0, id_valid}, 32'd1);
        step();
        chk("zero.pc",    id_pc,    32'h0000_0000);
        chk("zero.instr", id_instr, 32'h8C00_0000);

        // Asynchronous reset between edges while ID holds a valid word
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid", {31'b0, id_valid}, 32'd0);
        chk("arst.pc",    id_pc,    32'h0040_0000);
        chk("arst.instr", id_instr, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("arel.pc",    id_pc, 32'h0040_0000);
        chk("arel.valid", {31'b0, id_valid}, 32'd1);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_if_id_reg
`default_nettype wire

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00400000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000000, meaning the bubble instruction (sll $0,$0,0).
REQ-003 SHALL have ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low; asserted when 0.
- if_pc  input  32  current fetch address from the PC register.
- imem_rdata  input  32  instruction memory read data; synchronous read, 1-cycle latency from address.
- stall  input  1  hazard unit hold request; freezes the ID stage contents.
- flush  input  1  branch/jump taken; kills the in-flight fetch and the ID contents.
- imem_addr  output  32  instruction memory address, combinational copy of if_pc.
- imem_en  output  1  memory read enable; when 0 the memory keeps its previous rdata.
- id_pc  output  32  address of the instruction held in ID.
- id_pc_plus4  output  32  id_pc + 4.
- id_instr  output  32  instruction held in ID.
- id_valid  output  1  1 = id_instr is a real instruction; 0 = bubble.

Function
REQ-004 SHALL drive imem_addr = if_pc and imem_en = ~stall combinationally.
REQ-005 SHALL keep an internal fetch-tag register (fetch_pc, fetch_live) that records, every non-stalled cycle, the if_pc of that cycle and whether that fetch is live, so that imem_rdata returned in cycle N+1 is paired with the address issued in cycle N.
REQ-006 SHALL implement a 3-state FSM:
- RUN: normal operation.
- HOLD: entered while stall=1.
- SQUASH: entered for exactly one cycle after flush.
REQ-007 SHALL, in RUN with stall=0 and flush=0, load id_pc<=fetch_pc, id_instr<=imem_rdata, and id_valid<=fetch_live on each edge, and set fetch_live<=1.
REQ-008 SHALL, while stall=1 and flush=0, hold id_pc, id_instr, id_valid, fetch_pc, and fetch_live unchanged, and go to HOLD.
REQ-009 SHALL, in HOLD with stall deasserted, resume RUN behaviour on that same edge with no lost or duplicated instruction.
REQ-010 SHALL, on flush=1, override stall: load id_instr<=NOP_INSTR and id_valid<=0, set fetch_live<=0, and go to SQUASH.
REQ-011 SHALL, in SQUASH with no new flush, treat the returned rdata as dead (id_valid<=0, id_instr<=NOP_INSTR), then return to RUN with fetch_live<=1.
REQ-012 SHALL, on flush during SQUASH, restart the SQUASH cycle.
REQ-013 SHALL, on stall=1 in SQUASH, hold in SQUASH until stall drops; the dead fetch is never exposed.
REQ-014 SHALL compute id_pc_plus4 combinationally as id_pc + 32'd4, 32-bit modulo, with 0xFFFFFFFC wrapping to 0x00000000.
REQ-015 SHALL always drive id_instr = NOP_INSTR whenever id_valid = 0.

Reset
REQ-016 SHALL, while reset=0, force asynchronously: FSM=SQUASH, fetch_pc=RESET_PC, fetch_live=0, id_pc=RESET_PC, id_instr=NOP_INSTR, id_valid=0.
REQ-017 SHALL discard any in-flight fetch when reset asserts mid-operation.
REQ-018 SHALL, after reset releases, produce the first valid ID instruction with id_pc=RESET_PC, two edges after release, with stall=0.

Structure
REQ-019 SHALL take RESET_PC, NOP_INSTR, and the FSM state encoding (RUN=2'd0, HOLD=2'd1, SQUASH=2'd2) from the shared pipeline package, which the pc block also uses.
REQ-020 SHALL be a single module with no sub-modules; the adder is inline.

Verification
REQ-021 SHALL cover: reset release, imem returning 0x20080005 for 0x00400000 -> second edge gives id_pc=0x00400000, id_instr=0x20080005, id_valid=1, id_pc_plus4=0x00400004.
REQ-022 SHALL cover: stall held 3 cycles mid-stream -> id_* frozen for all 3 cycles, imem_en=0, next instruction appears exactly once afterwards.
REQ-023 SHALL cover: flush at id_pc=0x00400008 -> next edge id_valid=0, id_instr=0; following edge also a bubble; target instruction valid on the third edge.
REQ-024 SHALL cover: flush and stall asserted in the same cycle -> flush wins, id_valid=0, FSM=SQUASH.
REQ-025 SHALL cover: reset asserted asynchronously between edges while id_valid=1 -> id_valid falls immediately, id_pc=0x00400000.
REQ-026 SHALL cover: id_pc=0xFFFFFFFC -> id_pc_plus4=0x00000000.
